// File: rtl/serial_addsub_driver_if.sv
// Parallel-side bus of the bit-serial add/subtract driver.
// The master side is the environment: the requester that issues operations
// and the external bit-serial adder that returns ser_s.
interface serial_addsub_driver_if #(
  parameter int W = 8
) ();
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         ready;
  logic         ser_a;
  logic         ser_b;
  logic         ser_s;
  logic [W-1:0] result;
  logic         overflow;
  logic         done;

  modport master (
    output start, sub, op_a, op_b, ser_s,
    input  ready, ser_a, ser_b, result, overflow, done
  );

  modport slave (
    input  start, sub, op_a, op_b, ser_s,
    output ready, ser_a, ser_b, result, overflow, done
  );
endinterface

// File: rtl/serial_addsub_driver.sv
// Parallel-side controller for a bit-serial two's-complement adder with a
// single carry flop. Operands are shifted out LSB-first, the adder's sum bit
// is collected into a parallel result, and signed overflow is flagged.
// Subtraction is a + ~b + 1: B is inverted at accept and the adder carry is
// preset to 1 by a one-cycle flush with both serial bits driven to 1.
module serial_addsub_driver #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_addsub_driver_if.slave bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    SHIFT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_nxt;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;        // B as fed to the adder (inverted for sub)
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          ready_q, ready_d;
  logic          ser_a_q, ser_a_d;
  logic          ser_b_q, ser_b_d;
  logic          done_q, done_d;

  assign cnt_nxt = cnt_q + 1'b1;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; an unassigned path in always_comb infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    ready_d  = ready_q;
    ser_a_d  = ser_a_q;
    ser_b_d  = ser_b_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Zero serial bits keep the adder carry cleared while idle.
        ser_a_d = 1'b0;
        ser_b_d = 1'b0;
        ready_d = 1'b1;
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.sub ? ~bus.op_b : bus.op_b;
          // Driving sub on both inputs loads the adder carry with sub.
          ser_a_d = bus.sub;
          ser_b_d = bus.sub;
          ready_d = 1'b0;
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        cnt_d   = '0;
        ser_a_d = a_q[0];
        ser_b_d = b_q[0];
        state_d = SHIFT;
      end

      SHIFT: begin
        result_d[cnt_q] = bus.ser_s;
        if (cnt_q == LAST) begin
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.ser_s != a_q[W-1]);
          ser_a_d = 1'b0;
          ser_b_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_nxt;
          ser_a_d = a_q[cnt_nxt];
          ser_b_d = b_q[cnt_nxt];
        end
      end

      DONE: begin
        ser_a_d = 1'b0;
        ser_b_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: begin
        ser_a_d = 1'b0;
        ser_b_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      ser_a_q  <= 1'b0;
      ser_b_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      ser_a_q  <= ser_a_d;
      ser_b_q  <= ser_b_d;
      done_q   <= done_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.ser_a    = ser_a_q;
  assign bus.ser_b    = ser_b_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_serial_addsub_driver.sv
// Bench for serial_addsub_driver: models the external one-flop bit-serial
// adder, drives directed and random operations, and compares against signed
// integer arithmetic.
module tb_serial_addsub_driver;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_addsub_driver_if #(.W(W)) bus ();

  serial_addsub_driver #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // External bit-serial adder: sum is combinational, carry is one flop.
  logic carry_q = 1'b0;
  always @(posedge clk)
    carry_q <= (bus.ser_a & bus.ser_b) | (bus.ser_a & carry_q) | (bus.ser_b & carry_q);
  assign bus.ser_s = bus.ser_a ^ bus.ser_b ^ carry_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, wrapped to W bits.
  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, output logic [W-1:0] r, output logic v);
    int sa, sb, t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = s ? (sa - sb) : (sa + sb);
    r  = W'(t);
    v  = (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
  endfunction

  // Runs one operation from a negedge with ready expected high; ends on the
  // negedge where ready has returned. hold keeps start asserted throughout,
  // poke issues a start with a=0x11 in the middle of SHIFT.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit hold, input bit poke);
    logic [W-1:0] er, beff;
    logic         ev;
    ref_op(a, b, s, er, ev);
    beff = s ? ~b : b;
    check("ready_before_accept", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (k <= W + 2) begin
        check("done_timing", 32'(bus.done), 32'(k == W + 2));
        check("ready_busy", 32'(bus.ready), 32'd0);
      end
      if (k == 1) begin
        check("flush_ser_a", 32'(bus.ser_a), 32'(s));
        check("flush_ser_b", 32'(bus.ser_b), 32'(s));
      end else if (k <= W + 1) begin
        check("shift_ser_a", 32'(bus.ser_a), 32'(a[k-2]));
        check("shift_ser_b", 32'(bus.ser_b), 32'(beff[k-2]));
      end
      if (k == W + 2) begin
        check("result", 32'(bus.result), 32'(er));
        check("overflow", 32'(bus.overflow), 32'(ev));
        check("done_ser_a", 32'(bus.ser_a), 32'd0);
        check("done_ser_b", 32'(bus.ser_b), 32'd0);
      end
      if (k == W + 3) begin
        check("ready_after", 32'(bus.ready), 32'd1);
        check("no_extra_done", 32'(bus.done), 32'd0);
      end
      // Operand inputs wander while busy; they must have no effect.
      bus.start = hold || (poke && k == 5);
      if (poke && k == 5) begin
        bus.op_a = 8'h11;
        bus.op_b = 8'h00;
        bus.sub  = 1'b0;
      end else begin
        bus.op_a = W'($urandom);
        bus.op_b = W'($urandom);
        bus.sub  = 1'($urandom);
      end
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_done", 32'(bus.done), 32'd0);
      check("idle_ready", 32'(bus.ready), 32'd1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_ser_a", 32'(bus.ser_a), 32'd0);
    check("rst_ser_b", 32'(bus.ser_b), 32'd0);
    rst_n = 1'b1;
    idle_check(2);

    // Directed arithmetic cases.
    do_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
    do_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    do_op(8'h00, 8'h80, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    idle_check(1);

    // Start pulsed while busy is ignored.
    do_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b1);
    idle_check(3);

    // Back-to-back with start held: overflowing add then 0x00-0x01.
    do_op(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
    do_op(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    idle_check(1);

    // Reset in the middle of SHIFT (upper result bits still hold 0xFF).
    bus.start = 1'b1;
    bus.op_a  = 8'h05;
    bus.op_b  = 8'h03;
    bus.sub   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_ser_a", 32'(bus.ser_a), 32'd0);
    check("midrst_ser_b", 32'(bus.ser_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(1);
    do_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0);

    // Random operations, some back-to-back.
    for (int i = 0; i < 24; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), (i % 4) == 1, 1'b0);
    end
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
